// File: rtl/sobel_edge_pkg.sv
// Shared image-pipeline package.
// Holds the frame geometry (IMG_W, IMG_H, PIX_W), the gradient width,
// the sobel_edge state encoding and a small magnitude helper.
package sobel_edge_pkg;

    localparam int IMG_W  = 64;          // pixels per row
    localparam int IMG_H  = 64;          // rows per frame
    localparam int PIX_W  = 8;           // pixel width
    localparam int GRAD_W = PIX_W + 3;   // signed gradient / unsigned magnitude width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    // Absolute value of a signed gradient; the operand never reaches the most
    // negative code, so the negation cannot overflow.
    function automatic logic [GRAD_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] v);
        logic [GRAD_W-1:0] r;
        if (v[GRAD_W-1]) begin
            r = $unsigned(-v);
        end else begin
            r = $unsigned(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/sobel_edge_line_buffer.sv
// line_buffer: DEPTH-deep, WIDTH-wide delay line advanced only when en is high.
// Ports:
//   clk  - clock
//   en   - advance the line by one position
//   din  - value entering the line
//   dout - value that entered DEPTH enabled cycles ago
// Contents are deliberately not reset; the consumer masks anything stale.
module line_buffer #(
    parameter int DEPTH = sobel_edge_pkg::IMG_W,
    parameter int WIDTH = sobel_edge_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps_r [DEPTH];

    // Shift the whole line by one position per enabled cycle
    always_ff @(posedge clk) begin
        if (en) begin
            taps_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_r[i] <= taps_r[i-1];
            end
        end
    end

    assign dout = taps_r[DEPTH-1];

endmodule

// File: rtl/sobel_edge.sv
// sobel_edge: streaming 3x3 Sobel edge-magnitude filter over a raster frame.
// Ports:
//   clk       - single clock
//   reset     - asynchronous active-high reset
//   in        - input pixel, raster order
//   in_valid  - qualifies in for one cycle (no backpressure)
//   out       - edge magnitude pixel, held while out_valid is low
//   out_valid - qualifies out for one cycle
//   done      - pulses with the last output of a frame
// The newest accepted pixel is the bottom-right of the window, so the result
// for output index k-(IMG_W+1) is produced when pixel k is accepted.  The
// final IMG_W+1 outputs (bottom border) are emitted during FLUSH with no input.
// IMG_W and IMG_H are assumed to be powers of two.
module sobel_edge #(
    parameter int IMG_W = sobel_edge_pkg::IMG_W,
    parameter int IMG_H = sobel_edge_pkg::IMG_H,
    parameter int PIX_W = sobel_edge_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] in,
    input  logic             in_valid,
    output logic [PIX_W-1:0] out,
    output logic             out_valid,
    output logic             done
);
    import sobel_edge_pkg::*;

    localparam int COL_W   = $clog2(IMG_W);
    localparam int ROW_W   = $clog2(IMG_H);
    localparam int CNT_W   = COL_W + ROW_W;
    localparam int FLUSH_W = $clog2(IMG_W + 2);
    localparam int SUM_W   = GRAD_W - 1;

    localparam logic [CNT_W-1:0]   K_FIRST    = CNT_W'(IMG_W + 1);
    localparam logic [CNT_W-1:0]   K_LAST     = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(IMG_W);

    state_e               state_r, state_nxt_s;
    logic [CNT_W-1:0]     k_r;
    logic [FLUSH_W-1:0]   flush_cnt_r;
    logic                 accept_s, emit_s, done_s;

    logic [PIX_W-1:0]     lb1_s, lb2_s;
    logic [PIX_W-1:0]     top_l_r, top_m_r, mid_l_r, mid_m_r, bot_l_r, bot_m_r;

    logic [SUM_W-1:0]     sum_right_s, sum_left_s, sum_bot_s, sum_top_s;
    logic signed [GRAD_W-1:0] gx_s, gy_s;
    logic [GRAD_W-1:0]    mag_s;
    logic [PIX_W-1:0]     edge_s, pix_nxt_s;

    logic [CNT_W-1:0]     oidx_s;
    logic [ROW_W-1:0]     row_s;
    logic [COL_W-1:0]     col_s;
    logic                 interior_s;

    // Input is ignored while the bottom border is flushed out
    assign accept_s = in_valid && (state_r != FLUSH);

    // Previous row (lb1) and the row before it (lb2)
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .en   (accept_s),
        .din  (in),
        .dout (lb1_s)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk  (clk),
        .en   (accept_s),
        .din  (lb1_s),
        .dout (lb2_s)
    );

    // Window columns: current column is {lb2_s, lb1_s, in}; _m_ and _l_ hold the two older ones
    always_ff @(posedge clk) begin
        if (accept_s) begin
            top_l_r <= top_m_r;
            mid_l_r <= mid_m_r;
            bot_l_r <= bot_m_r;
            top_m_r <= lb2_s;
            mid_m_r <= lb1_s;
            bot_m_r <= in;
        end
    end

    // Sobel arithmetic; each weighted sum is at most 4*max pixel so SUM_W bits suffice
    always_comb begin
        sum_right_s = SUM_W'(lb2_s)   + (SUM_W'(lb1_s)   << 1) + SUM_W'(in);
        sum_left_s  = SUM_W'(top_l_r) + (SUM_W'(mid_l_r) << 1) + SUM_W'(bot_l_r);
        sum_bot_s   = SUM_W'(bot_l_r) + (SUM_W'(bot_m_r) << 1) + SUM_W'(in);
        sum_top_s   = SUM_W'(top_l_r) + (SUM_W'(top_m_r) << 1) + SUM_W'(lb2_s);
        gx_s        = $signed({1'b0, sum_right_s}) - $signed({1'b0, sum_left_s});
        gy_s        = $signed({1'b0, sum_bot_s})   - $signed({1'b0, sum_top_s});
        mag_s       = grad_abs(gx_s) + grad_abs(gy_s);
        if (|mag_s[GRAD_W-1:PIX_W]) begin
            edge_s = {PIX_W{1'b1}};
        end else begin
            edge_s = mag_s[PIX_W-1:0];
        end
    end

    // Position of the pixel centred in the window, for border masking
    always_comb begin
        oidx_s     = k_r - K_FIRST;
        row_s      = oidx_s[CNT_W-1:COL_W];
        col_s      = oidx_s[COL_W-1:0];
        interior_s = (row_s != ROW_W'(0)) && (row_s != ROW_W'(IMG_H - 1)) &&
                     (col_s != COL_W'(0)) && (col_s != COL_W'(IMG_W - 1));
        if ((state_r != FLUSH) && interior_s) begin
            pix_nxt_s = edge_s;
        end else begin
            pix_nxt_s = '0;
        end
    end

    assign emit_s = (accept_s && ((state_r == FILL) || (state_r == RUN)) && (k_r >= K_FIRST)) ||
                    (state_r == FLUSH);
    assign done_s = (state_r == FLUSH) && (flush_cnt_r == FLUSH_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nxt_s = FILL;
                else          state_nxt_s = IDLE;
            end
            FILL: begin
                if (accept_s && (k_r == K_FIRST)) state_nxt_s = RUN;
                else                              state_nxt_s = FILL;
            end
            RUN: begin
                if (accept_s && (k_r == K_LAST)) state_nxt_s = FLUSH;
                else                             state_nxt_s = RUN;
            end
            FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) state_nxt_s = IDLE;
                else                           state_nxt_s = FLUSH;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pixel index of the next accepted input; restarts for every frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r <= '0;
        end else if (state_r == FLUSH) begin
            k_r <= '0;
        end else if (accept_s) begin
            k_r <= k_r + CNT_W'(1);
        end else begin
            k_r <= k_r;
        end
    end

    // Number of flush outputs already emitted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_r <= '0;
        end else if (state_r == FLUSH) begin
            flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
        end else begin
            flush_cnt_r <= '0;
        end
    end

    // Registered outputs; out holds its value between results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= emit_s;
            done      <= done_s;
            if (emit_s) begin
                out <= pix_nxt_s;
            end else begin
                out <= out;
            end
        end
    end

endmodule

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 SHALL have parameters: IMG_W, default 64, pixels per row; IMG_H, default 64, rows per frame; PIX_W, default 8, pixel width.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port in, input, 8, pixel from the 64x64 scaler output, raster order.
REQ-005 SHALL have port in_valid, input, 1, qualifies in for one cycle; driven by the scaler's display; no backpressure.
REQ-006 SHALL have port out, output, 8, edge magnitude pixel.
REQ-007 SHALL have port out_valid, output, 1, qualifies out for one cycle.
REQ-008 SHALL have port done, output, 1, one-cycle pulse coincident with the 4096th out_valid of a frame.

Function
REQ-009 SHALL accept exactly IMG_W*IMG_H (4096) input pixels per frame, indexed k=0..4095, row=k/64, col=k%64.
REQ-010 SHALL use states IDLE, FILL, RUN, FLUSH; IDLE->FILL on the first in_valid; FILL->RUN on accepting k=65; RUN->FLUSH on accepting k=4095; FLUSH->IDLE after the 65th flush output.
REQ-011 SHALL, on accepting input k>=65, register output index k-65 and assert out_valid on the next cycle (latency 1 cycle from in_valid).
REQ-012 SHALL produce no output while k<=64 (FILL).
REQ-013 SHALL output 0 for every border pixel (row 0, row 63, col 0, col 63).
REQ-014 SHALL, for interior pixel (r,c), output min(|Gx|+|Gy|, 255); Gx=(p[r-1][c+1]+2p[r][c+1]+p[r+1][c+1])-(p[r-1][c-1]+2p[r][c-1]+p[r+1][c-1]); Gy=(p[r+1][c-1]+2p[r+1][c]+p[r+1][c+1])-(p[r-1][c-1]+2p[r-1][c]+p[r-1][c+1]).
REQ-015 SHALL compute Gx and Gy as 11-bit signed values and |Gx|+|Gy| as 11-bit unsigned before saturating; no intermediate overflow.
REQ-016 SHALL, in FLUSH, emit output indices 4031..4095 (all border, value 0) on 65 consecutive cycles without input.
REQ-017 SHALL ignore and drop in_valid during FLUSH.
REQ-018 SHALL tolerate arbitrary idle gaps between in_valid pulses (e.g. one pulse every 2 cycles); outputs track inputs one-for-one.
REQ-019 SHALL emit exactly 4096 out_valid pulses per frame, in raster order.
REQ-020 SHALL accept a new frame starting the cycle after returning to IDLE; counters and window restart at k=0.
REQ-021 SHALL hold out at its last value when out_valid is low.

Reset
REQ-022 SHALL, on reset assertion, asynchronously set out=0, out_valid=0, done=0, state=IDLE, pixel counter=0.
REQ-023 SHALL abandon a partial frame on reset mid-operation; no out_valid until a new frame reaches k=65.
REQ-024 SHALL NOT require line-buffer contents to be cleared by reset.

Structure
REQ-025 SHALL place IMG_W, IMG_H, PIX_W and the state encoding in the shared image-pipeline package.
REQ-026 SHALL instantiate sub-module line_buffer (IMG_W-deep, PIX_W-wide delay line with enable) twice for the two previous rows; 3x3 window registers and arithmetic in sobel_edge.

Verification
REQ-027 SHALL verify flat image all 100 -> 4096 outputs all 0, done pulses once.
REQ-028 SHALL verify vertical step (col<32:0, col>=32:255) -> 255 at interior rows cols 31 and 32, 0 elsewhere.
REQ-029 SHALL verify horizontal ramp pixel=4*col -> 32 at every interior pixel, 0 on border.
REQ-030 SHALL verify in_valid every 2nd cycle vs every cycle -> identical output sequences; 65 zero outputs on consecutive cycles after the last input.
REQ-031 SHALL verify reset asserted at k=2000, then a full flat-100 frame -> exactly 4096 zero outputs, no stale data.
REQ-032 SHALL verify in_valid pulses during FLUSH -> dropped, output count still 4096, state reaches IDLE.
